// File: rtl/traffic_phase_sequencer_if.sv
// rtl/traffic_phase_sequencer_if.sv - request/lamp bundle between the phase sequencer and its board
interface traffic_phase_sequencer_if #(
    parameter int NUM_DIR = 4
);
    localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

    logic [NUM_DIR-1:0]   demand;
    logic                 emerg_req;
    logic [DIR_W-1:0]     emerg_dir;
    logic                 flash_req;
    logic [2*NUM_DIR-1:0] lights;
    logic [DIR_W-1:0]     active_dir;
    logic [2:0]           state_o;
    logic                 sec_tick;
    logic                 emerg_ack;

    // master is the sequencer itself; slave is the board side that raises requests
    modport master (
        input  demand, emerg_req, emerg_dir, flash_req,
        output lights, active_dir, state_o, sec_tick, emerg_ack
    );

    modport slave (
        output demand, emerg_req, emerg_dir, flash_req,
        input  lights, active_dir, state_o, sec_tick, emerg_ack
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - N-way intersection phase sequencer with demand skip, pre-emption and night flash
module traffic_phase_sequencer #(
    parameter int NUM_DIR   = 4,
    parameter int TICK_DIV  = 50000000,
    parameter int GREEN_S   = 5,
    parameter int YELLOW_S  = 1,
    parameter int ALLRED_S  = 1,
    parameter int STARTUP_S = 2
) (
    input  logic clk,
    input  logic rst,
    traffic_phase_sequencer_if.master bus
);
    localparam int DIR_W  = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;
    localparam int DIR_WX = DIR_W + 1;
    localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    PRE_LAST     = PW'(TICK_DIV - 1);
    localparam logic [15:0]      STARTUP_LAST = 16'(STARTUP_S - 1);
    localparam logic [15:0]      GREEN_LAST   = 16'(GREEN_S - 1);
    localparam logic [15:0]      YELLOW_LAST  = 16'(YELLOW_S - 1);
    localparam logic [15:0]      ALLRED_LAST  = 16'(ALLRED_S - 1);
    localparam logic [DIR_W:0]   DIR_LIMIT    = DIR_WX'(NUM_DIR);
    localparam logic [DIR_W-1:0] LAST_DIR     = DIR_W'(NUM_DIR - 1);

    localparam logic [1:0] L_RED = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_GRN = 2'b10;
    localparam logic [1:0] L_OFF = 2'b11;

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_ALLRED  = 3'd3,
        ST_EMERG   = 3'd4,
        ST_FLASH   = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [PW-1:0]        presc, presc_n;
    logic [15:0]          sec_cnt, sec_n;
    logic [15:0]          dwell_last;
    logic [DIR_W-1:0]     dir, dir_n;
    logic [DIR_W-1:0]     rr_dir, cand;
    logic                 rr_found;
    logic [2*NUM_DIR-1:0] lights_q, lights_n;
    logic [1:0]           code;
    logic                 tick_q, ack_q;
    logic                 tick, expire, emerg_ok;

    // Round-robin pick: first requesting lane after the current owner, else plain rotation
    always_comb begin
        rr_dir   = (dir == LAST_DIR) ? '0 : dir + 1'b1;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_DIR; k++) begin
            if (!rr_found) begin
                cand = DIR_W'((int'(dir) + k) % NUM_DIR);
                if (bus.demand[cand]) begin
                    rr_dir   = cand;
                    rr_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        tick     = (presc == PRE_LAST);
        emerg_ok = bus.emerg_req && ({1'b0, bus.emerg_dir} < DIR_LIMIT);

        case (state)
            ST_STARTUP: dwell_last = STARTUP_LAST;
            ST_GREEN:   dwell_last = GREEN_LAST;
            ST_YELLOW:  dwell_last = YELLOW_LAST;
            ST_ALLRED:  dwell_last = ALLRED_LAST;
            default:    dwell_last = '1;
        endcase
        expire = tick && (sec_cnt == dwell_last);

        state_n = state;
        dir_n   = dir;
        case (state)
            ST_STARTUP: if (expire) state_n = ST_ALLRED;
            ST_GREEN: begin
                // Pre-emption for the lane already green skips clearance entirely
                if (emerg_ok && (bus.emerg_dir == dir)) state_n = ST_EMERG;
                else if (emerg_ok || expire)             state_n = ST_YELLOW;
            end
            ST_YELLOW: if (expire) state_n = ST_ALLRED;
            ST_ALLRED: begin
                if (expire) begin
                    if (emerg_ok) begin
                        state_n = ST_EMERG;
                        dir_n   = bus.emerg_dir;
                    end else if (bus.flash_req) begin
                        state_n = ST_FLASH;
                    end else begin
                        state_n = ST_GREEN;
                        dir_n   = rr_dir;
                    end
                end
            end
            ST_EMERG: if (!bus.emerg_req) state_n = ST_YELLOW;
            ST_FLASH: if (tick && (!bus.flash_req || emerg_ok)) state_n = ST_ALLRED;
            default:  state_n = ST_STARTUP;
        endcase

        if (state_n != state) begin
            presc_n = '0;
            sec_n   = '0;
        end else if (tick) begin
            presc_n = '0;
            sec_n   = sec_cnt + 16'd1;
        end else begin
            presc_n = presc + 1'b1;
            sec_n   = sec_cnt;
        end

        // Lamp codes are decoded from the next state so they register alongside it
        lights_n = '0;
        code     = L_RED;
        for (int i = 0; i < NUM_DIR; i++) begin
            case (state_n)
                ST_STARTUP:         code = L_YEL;
                ST_GREEN, ST_EMERG: code = (DIR_W'(i) == dir_n) ? L_GRN : L_RED;
                ST_YELLOW:          code = (DIR_W'(i) == dir_n) ? L_YEL : L_RED;
                ST_FLASH:           code = sec_n[0] ? L_OFF : L_YEL;
                default:            code = L_RED;
            endcase
            lights_n[2*i +: 2] = code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_STARTUP;
            presc    <= '0;
            sec_cnt  <= '0;
            dir      <= LAST_DIR;
            lights_q <= {NUM_DIR{L_YEL}};
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            sec_cnt  <= sec_n;
            dir      <= dir_n;
            lights_q <= lights_n;
            tick_q   <= (presc_n == PRE_LAST);
            ack_q    <= (state_n == ST_EMERG);
        end
    end

    assign bus.lights     = lights_q;
    assign bus.active_dir = dir;
    assign bus.state_o    = state;
    assign bus.sec_tick   = tick_q;
    assign bus.emerg_ack  = ack_q;
endmodule
